// File: rtl/nco_sweep_ctrl.sv
// Linear frequency-sweep sequencer feeding the NCO phase increment.
// Steps start->stop by a fixed step, holding each value for a dwell period.
module nco_sweep_ctrl #(
  parameter int PHASE_W = 32,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_start_inc,
  input  logic [PHASE_W-1:0] cfg_stop_inc,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  input  logic               start,
  input  logic               abort,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               busy,
  output logic               step_strobe,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [PHASE_W-1:0] start_reg, stop_reg, step_reg;
  logic [DWELL_W-1:0] dwell_reg, cnt_reg;
  logic               loop_reg, up_reg;

  logic               take;
  logic [PHASE_W-1:0] eff_start, eff_stop;
  logic [DWELL_W-1:0] eff_dwell;
  logic [PHASE_W:0]   sum, diff;
  logic [PHASE_W-1:0] next_inc;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);

  // A config word arriving with start in IDLE is used for that very sweep.
  assign take      = cfg_valid && (state == IDLE);
  assign eff_start = take ? cfg_start_inc : start_reg;
  assign eff_stop  = take ? cfg_stop_inc  : stop_reg;
  assign eff_dwell = take ? cfg_dwell     : dwell_reg;

  function automatic logic [DWELL_W-1:0] reload(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  // One extra bit catches overflow/underflow so the clamp never wraps.
  always_comb begin
    sum      = {1'b0, phase_inc} + {1'b0, step_reg};
    diff     = {1'b0, phase_inc} - {1'b0, step_reg};
    next_inc = stop_reg;
    if (up_reg) begin
      if (step_reg != '0 && sum < {1'b0, stop_reg})
        next_inc = sum[PHASE_W-1:0];
    end else begin
      if (step_reg != '0 && !diff[PHASE_W] && diff[PHASE_W-1:0] > stop_reg)
        next_inc = diff[PHASE_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      start_reg   <= '0;
      stop_reg    <= '0;
      step_reg    <= '0;
      dwell_reg   <= '0;
      loop_reg    <= 1'b0;
      up_reg      <= 1'b1;
      cnt_reg     <= '0;
      phase_inc   <= '0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      if (take) begin
        start_reg <= cfg_start_inc;
        stop_reg  <= cfg_stop_inc;
        step_reg  <= cfg_step;
        dwell_reg <= cfg_dwell;
        loop_reg  <= cfg_loop;
      end
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state       <= RUN;
            phase_inc   <= eff_start;
            up_reg      <= (eff_stop >= eff_start);
            cnt_reg     <= reload(eff_dwell);
            step_strobe <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else if (phase_inc != stop_reg) begin
            phase_inc   <= next_inc;
            step_strobe <= 1'b1;
            cnt_reg     <= reload(dwell_reg);
          end else if (loop_reg) begin
            phase_inc   <= start_reg;
            step_strobe <= 1'b1;
            cnt_reg     <= reload(dwell_reg);
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: table vectors, hand-written corner
// sequences and random sweeps compared against a value-list reference model.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_start_inc = '0, cfg_stop_inc = '0, cfg_step = '0;
  logic [15:0] cfg_dwell = '0;
  logic        cfg_loop = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] phase_inc;
  logic        busy, step_strobe, done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  nco_sweep_ctrl #(.PHASE_W(32), .DWELL_W(16)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start_inc(cfg_start_inc), .cfg_stop_inc(cfg_stop_inc),
    .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop),
    .start(start), .abort(abort), .phase_inc(phase_inc), .busy(busy),
    .step_strobe(step_strobe), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s, st, stp;
    logic [15:0] d;
    int          mode;   // 1: config then start, 2: config with start
    int          n;
    logic [31:0] v[6];
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view: {phase_inc, step_strobe, busy, done, cfg_ready}
  function automatic logic [35:0] outs();
    return {phase_inc, step_strobe, busy, done, cfg_ready};
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: list of values the sweep visits, from the arithmetic rules.
  task automatic build_exp(input logic [31:0] s, input logic [31:0] st, input logic [31:0] stp);
    longint v, nv;
    bit up;
    up = (st >= s);
    exp_q.delete();
    v = s;
    exp_q.push_back(s);
    while (v != longint'(st)) begin
      if (up) begin
        nv = v + stp;
        if (stp == 0 || nv >= st) nv = st;
      end else begin
        if (stp == 0 || v <= longint'(st) + longint'(stp)) nv = st;
        else nv = v - stp;
      end
      v = nv;
      exp_q.push_back(v[31:0]);
    end
  endtask

  task automatic drive_cfg(input logic [31:0] s, input logic [31:0] st, input logic [31:0] stp,
                           input logic [15:0] d, input logic lp);
    cfg_valid = 1'b1;
    cfg_start_inc = s; cfg_stop_inc = st; cfg_step = stp; cfg_dwell = d; cfg_loop = lp;
  endtask

  // Runs a single-shot sweep expecting exp_q; ends in the done cycle.
  task automatic run_sweep(input int mode, input logic [31:0] s, input logic [31:0] st,
                           input logic [31:0] stp, input logic [15:0] d, input string tag);
    int de;
    int bad0;
    logic [31:0] last;
    de = (d == 0) ? 1 : int'(d);
    bad0 = n_bad;
    if (mode == 1) begin
      drive_cfg(s, st, stp, d, 1'b0);
      tick();
      cfg_valid = 1'b0;
    end else if (mode == 2) begin
      drive_cfg(s, st, stp, d, 1'b0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_valid = 1'b0;
    foreach (exp_q[i]) begin
      for (int k = 0; k < de; k++) begin
        check({tag, "_run"}, outs(), {exp_q[i], (k == 0), 1'b1, 1'b0, 1'b0});
        tick();
      end
    end
    last = exp_q[exp_q.size()-1];
    check({tag, "_done"}, outs(), {last, 1'b0, 1'b0, 1'b1, 1'b1});
    $display("sweep %s start=%0d stop=%0d step=%0d dwell=%0d values=%0d errors=%0d",
             tag, s, st, stp, d, exp_q.size(), n_bad - bad0);
  endtask

  initial begin
    logic [31:0] p, s, st, stp, base;
    logic [15:0] d;

    tbl[0] = '{s:100, st:130, stp:10, d:3, mode:1, n:4, v:'{100, 110, 120, 130, 0, 0}};
    tbl[1] = '{s:100, st:125, stp:10, d:1, mode:1, n:4, v:'{100, 110, 120, 125, 0, 0}};
    tbl[2] = '{s:130, st:100, stp:10, d:1, mode:2, n:4, v:'{130, 120, 110, 100, 0, 0}};
    tbl[3] = '{s:0, st:5, stp:32'hFFFF_FFFF, d:1, mode:1, n:2, v:'{0, 5, 0, 0, 0, 0}};
    tbl[4] = '{s:42, st:42, stp:7, d:2, mode:2, n:1, v:'{42, 0, 0, 0, 0, 0}};
    tbl[5] = '{s:10, st:30, stp:10, d:0, mode:1, n:3, v:'{10, 20, 30, 0, 0, 0}};
    tbl[6] = '{s:5, st:0, stp:0, d:2, mode:2, n:2, v:'{5, 0, 0, 0, 0, 0}};
    tbl[7] = '{s:50, st:3, stp:20, d:1, mode:2, n:4, v:'{50, 30, 10, 3, 0, 0}};

    tick();
    tick();
    check("reset_held", outs(), {32'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    reset = 1'b0;
    tick();
    check("reset_state", outs(), {32'd0, 1'b0, 1'b0, 1'b0, 1'b1});

    // Table vectors; mode 2 entries prove same-cycle config is used.
    for (int i = 0; i < 8; i++) begin
      exp_q.delete();
      for (int j = 0; j < tbl[i].n; j++) exp_q.push_back(tbl[i].v[j]);
      run_sweep(tbl[i].mode, tbl[i].s, tbl[i].st, tbl[i].stp, tbl[i].d, $sformatf("tbl%0d", i));
    end
    tick();
    check("done_pulse", outs(), {32'd3, 1'b0, 1'b0, 1'b0, 1'b1});

    // Loop mode, config change ignored in RUN, abort racing a dwell expiry.
    drive_cfg(0, 20, 10, 2, 1'b1);
    tick();
    cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 18; c++) begin
      check("loop_run", outs(), {((c / 2) % 3) * 32'd10, (c % 2 == 0), 1'b1, 1'b0, 1'b0});
      cfg_valid = (c == 5);
      if (c == 5) begin
        cfg_start_inc = 777; cfg_stop_inc = 999; cfg_step = 1; cfg_dwell = 9; cfg_loop = 0;
      end
      abort = (c == 17);
      tick();
    end
    cfg_valid = 1'b0;
    abort = 1'b0;
    check("loop_abort", outs(), {32'd20, 1'b0, 1'b0, 1'b0, 1'b1});
    tick();
    check("abort_hold", outs(), {32'd20, 1'b0, 1'b0, 1'b0, 1'b1});
    $display("sweep loop 0->20 step 10 dwell 2 aborted errors_so_far=%0d", n_bad);

    // Shadow registers must still hold the loop config.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("shadow_keep", outs(), {((c / 2) % 3) * 32'd10, (c % 2 == 0), 1'b1, 1'b0, 1'b0});
      abort = (c == 7);
      tick();
    end
    abort = 1'b0;
    check("abort2", outs(), {32'd0, 1'b0, 1'b0, 1'b0, 1'b1});

    // start with abort in IDLE starts nothing.
    p = phase_inc;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort", outs(), {p, 1'b0, 1'b0, 1'b0, 1'b1});
    tick();
    check("start_abort2", outs(), {p, 1'b0, 1'b0, 1'b0, 1'b1});
    $display("start+abort in IDLE errors_so_far=%0d", n_bad);

    // Async reset mid-dwell, then a sweep from the cleared shadow config.
    drive_cfg(100, 130, 10, 5, 1'b0);
    tick();
    cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_reset", outs(), {32'd100, 1'b0, 1'b1, 1'b0, 1'b0});
    #2 reset = 1'b1;
    #1;
    check("async_reset", outs(), {32'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    #1 reset = 1'b0;
    tick();
    build_exp(0, 0, 0);
    run_sweep(0, 0, 0, 0, 0, "post_reset");

    // Random single-shot sweeps, started in the previous done cycle.
    for (int i = 0; i < 30; i++) begin
      base = (i % 3 == 0) ? 32'hFFFF_FF00 : $urandom_range(0, 1000);
      s = base + $urandom_range(0, 200);
      st = base + $urandom_range(0, 200);
      stp = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 50);
      d = 16'($urandom_range(0, 3));
      build_exp(s, st, stp);
      run_sweep(($urandom_range(0, 1) == 0) ? 1 : 2, s, st, stp, d, $sformatf("rnd%0d", i));
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
